t_latch_toggle_arbiter: RTL and testbench

Round-robin arbiter and sequencer for a shared bank of WIDTH T latches. NUM_REQ requesters each submit a toggle mask. The block grants one requester at a time and drives the bank's EN and T inputs with exactly one enable cycle, followed by a guard gap with EN low. A level-sensitive T latch toggles continuously while EN=1 and T=1, so the single-cycle pulse and the gap keep every granted toggle to exactly one flip. The block also keeps a registered shadow of the bank state for readback.

---
 rtl/t_latch_toggle_arbiter.sv | 106 ++++++++++
 tb/tb_t_latch_toggle_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/t_latch_toggle_arbiter.sv
// Round-robin arbiter driving a shared T-latch bank with one-cycle EN pulses and a guard gap.
// Keeps a registered shadow of the bank contents for readback.
module t_latch_toggle_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned GAP_CYC = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*WIDTH-1:0] mask,
   output logic [NUM_REQ-1:0]       gnt,
   output logic                     lat_en,
   output logic [WIDTH-1:0]         lat_t,
   output logic [WIDTH-1:0]         q_shadow,
   output logic                     done,
   output logic                     busy
);

   localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned CntW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
   localparam logic [CntW-1:0] GapInit = (GAP_CYC == 0) ? '0 : CntW'(GAP_CYC - 1);

   typedef enum logic [1:0] {StIdle, StPulse, StGap} state_e;

   state_e             state_q;
   logic [PtrW-1:0]    ptr_q;
   logic [CntW-1:0]    gap_q;

   logic               found;
   int unsigned        idx;
   logic [PtrW-1:0]    ptr_nxt;
   logic [NUM_REQ-1:0] gnt_sel;
   logic [WIDTH-1:0]   mask_sel;

   // First requester at or above the pointer, wrapping around.
   always_comb begin
      found    = 1'b0;
      idx      = 0;
      ptr_nxt  = ptr_q;
      gnt_sel  = '0;
      mask_sel = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx = (32'(ptr_q) + k) % NUM_REQ;
         if (!found && req[idx]) begin
            found        = 1'b1;
            gnt_sel[idx] = 1'b1;
            mask_sel     = mask[idx*WIDTH +: WIDTH];
            ptr_nxt      = PtrW'((idx + 1) % NUM_REQ);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         ptr_q    <= '0;
         gap_q    <= '0;
         gnt      <= '0;
         lat_en   <= 1'b0;
         lat_t    <= '0;
         q_shadow <= '0;
         done     <= 1'b0;
         busy     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_q)
            StIdle: begin
               if (found) begin
                  state_q <= StPulse;
                  gnt     <= gnt_sel;
                  lat_t   <= mask_sel;
                  lat_en  <= 1'b1;
                  busy    <= 1'b1;
                  ptr_q   <= ptr_nxt;
               end
            end
            StPulse: begin
               lat_en   <= 1'b0;
               lat_t    <= '0;
               gnt      <= '0;
               q_shadow <= q_shadow ^ lat_t;
               done     <= 1'b1;
               // Leaving PULSE always drops EN, so back-to-back pulses cannot occur.
               if (GAP_CYC == 0) begin
                  state_q <= StIdle;
                  busy    <= 1'b0;
               end else begin
                  state_q <= StGap;
                  gap_q   <= GapInit;
               end
            end
            StGap: begin
               if (gap_q == '0) begin
                  state_q <= StIdle;
                  busy    <= 1'b0;
               end else begin
                  gap_q <= gap_q - 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_t_latch_toggle_arbiter.sv
// Self-checking bench: two arbiters (GAP_CYC=2 and GAP_CYC=0) against a timeline model
// that tracks edges elapsed since the last grant.
module tb_t_latch_toggle_arbiter;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req_a, req_b;
   logic [31:0] mask_a, mask_b;
   logic [3:0]  gnt_a, gnt_b;
   logic        en_a, en_b, done_a, done_b, busy_a, busy_b;
   logic [7:0]  t_a, t_b, q_a, q_b;

   int checks = 0;
   int errors = 0;

   // Model: edges since last grant, rr pointer, shadow, in-flight mask/grant per instance.
   int         d[2];
   int         ptr[2];
   logic [7:0] sh[2];
   logic [7:0] pm[2];
   logic [3:0] pg[2];
   logic       prev_en[2];

   t_latch_toggle_arbiter #(.NUM_REQ(4), .WIDTH(8), .GAP_CYC(2)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .req(req_a), .mask(mask_a), .gnt(gnt_a), .lat_en(en_a),
      .lat_t(t_a), .q_shadow(q_a), .done(done_a), .busy(busy_a)
   );

   t_latch_toggle_arbiter #(.NUM_REQ(4), .WIDTH(8), .GAP_CYC(0)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .req(req_b), .mask(mask_b), .gnt(gnt_b), .lat_en(en_b),
      .lat_t(t_b), .q_shadow(q_b), .done(done_b), .busy(busy_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge(input int k, input logic rst, input logic [3:0] r,
                             input logic [31:0] m);
      int g;
      int w;
      int c;
      g = (k == 0) ? 2 : 0;
      if (!rst) begin
         d[k]   = 1000;
         ptr[k] = 0;
         sh[k]  = 8'h00;
      end else begin
         // A new grant may start 2+GAP edges after the previous one.
         if (d[k] >= 1 + g && r != 4'h0) begin
            w = -1;
            for (int i = 0; i < 4; i++) begin
               c = (ptr[k] + i) % 4;
               if (w < 0 && r[c]) w = c;
            end
            d[k]   = 0;
            pm[k]  = m[w*8 +: 8];
            pg[k]  = 4'(1 << w);
            ptr[k] = (w + 1) % 4;
         end else if (d[k] < 1000) begin
            d[k]++;
         end
         if (d[k] == 1) sh[k] = sh[k] ^ pm[k];
      end
   endtask

   task automatic check_inst(input int k, input string p, input logic [3:0] g_o, input logic en,
                             input logic [7:0] t, input logic [7:0] q, input logic dn,
                             input logic bz);
      int  g;
      logic in_pulse;
      g        = (k == 0) ? 2 : 0;
      in_pulse = (d[k] == 0);
      chk({p, "_gnt"},    32'(g_o), in_pulse ? 32'(pg[k]) : 32'h0);
      chk({p, "_lat_en"}, 32'(en),  32'(in_pulse));
      chk({p, "_lat_t"},  32'(t),   in_pulse ? 32'(pm[k]) : 32'h0);
      chk({p, "_shadow"}, 32'(q),   32'(sh[k]));
      chk({p, "_done"},   32'(dn),  32'(d[k] == 1));
      chk({p, "_busy"},   32'(bz),  32'(d[k] <= g));
      chk({p, "_en_consec"}, 32'(prev_en[k] & en), 32'h0);
      prev_en[k] = en;
   endtask

   // Inputs are stable across the edge; model consumes the same values the DUTs sampled.
   task automatic step();
      logic        r;
      logic [3:0]  ra, rb;
      logic [31:0] ma, mb;
      r  = rst_n;
      ra = req_a;
      rb = req_b;
      ma = mask_a;
      mb = mask_b;
      @(posedge clk);
      #1;
      model_edge(0, r, ra, ma);
      model_edge(1, r, rb, mb);
      check_inst(0, "a", gnt_a, en_a, t_a, q_a, done_a, busy_a);
      check_inst(1, "b", gnt_b, en_b, t_b, q_b, done_b, busy_b);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      prev_en[0] = 1'b0;
      prev_en[1] = 1'b0;
      d[0] = 1000; d[1] = 1000;
      ptr[0] = 0;  ptr[1] = 0;
      sh[0] = '0;  sh[1] = '0;
      pm[0] = '0;  pm[1] = '0;
      pg[0] = '0;  pg[1] = '0;

      // Reset held with all requests pending; GAP_CYC=0 instance alternates 0,1 throughout.
      rst_n  = 1'b0;
      req_a  = 4'hF;
      mask_a = 32'hFFFF_FFFF;
      req_b  = 4'b0011;
      mask_b = 32'h0000_0201;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_lat_en", 32'(en_a), 32'h0);
      end
      rst_n = 1'b1;
      step();
      chk("first_gnt_req0", 32'(gnt_a), 32'h1);
      req_a = 4'h0;
      for (int i = 0; i < 5; i++) step();

      // Single request from requester 2.
      do_reset();
      req_a  = 4'b0100;
      mask_a = 32'h00A5_0000;
      step();
      chk("t2_gnt", 32'(gnt_a), 32'h4);
      chk("t2_lat_t", 32'(t_a), 32'hA5);
      req_a  = 4'h0;
      mask_a = 32'h0000_0000;
      step();
      chk("t2_done", 32'(done_a), 32'h1);
      chk("t2_shadow", 32'(q_a), 32'hA5);
      step();
      chk("t2_busy_gap", 32'(busy_a), 32'h1);
      step();
      chk("t2_busy_end", 32'(busy_a), 32'h0);

      // All requesting with mask 01: round-robin order, shadow alternates.
      req_a  = 4'hF;
      mask_a = 32'h0101_0101;
      do_reset();
      for (int i = 0; i < 20; i++) step();

      // Requester 0 repeating with mask 0F.
      req_a  = 4'b0001;
      mask_a = 32'h0000_000F;
      do_reset();
      for (int i = 0; i < 10; i++) step();

      // Reset during the pulse cycle.
      req_a  = 4'b0010;
      mask_a = 32'h0000_3C00;
      do_reset();
      step();
      chk("t5_gnt", 32'(gnt_a), 32'h2);
      rst_n = 1'b0;
      req_a = 4'h0;
      step();
      chk("t5_lat_en", 32'(en_a), 32'h0);
      chk("t5_shadow", 32'(q_a), 32'h0);
      rst_n = 1'b1;
      step();
      chk("t5_no_done", 32'(done_a), 32'h0);

      // Randomized traffic with occasional resets and mid-flight mask changes.
      for (int i = 0; i < 400; i++) begin
         rst_n  = ($urandom_range(0, 39) != 0);
         req_a  = 4'($urandom);
         mask_a = $urandom;
         req_b  = 4'($urandom);
         mask_b = $urandom;
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
